// File: rtl/change_dispenser_if.sv
// Coin payout handshake bundle: the vending controller side (start/amount/
// refill), the hopper side (eject/coin/ack) and the transaction status.
interface change_dispenser_if;
  logic        I_START;
  logic [15:0] I_AMOUNT;
  logic        I_REFILL;
  logic        O_EJECT;
  logic [2:0]  O_COIN;
  logic        I_EJECT_ACK;
  logic        O_BUSY;
  logic        O_DONE;
  logic [15:0] O_SHORT;
  logic [7:0]  O_COINS_OUT;

  // The dispenser itself
  modport slave (
    input  I_START, I_AMOUNT, I_REFILL, I_EJECT_ACK,
    output O_EJECT, O_COIN, O_BUSY, O_DONE, O_SHORT, O_COINS_OUT
  );

  // Whatever drives the dispenser (controller plus hopper)
  modport master (
    output I_START, I_AMOUNT, I_REFILL, I_EJECT_ACK,
    input  O_EJECT, O_COIN, O_BUSY, O_DONE, O_SHORT, O_COINS_OUT
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin payout unit: latches a change amount, then ejects coins one at
// a time (largest denomination that fits and is still stocked), and reports
// the coin count plus whatever could not be paid.
module change_dispenser #(
  parameter int INV_W    = 8,
  parameter int INV_INIT = 20
) (
  input logic               CLK,
  input logic               I_RESET_N,
  change_dispenser_if.slave bus
);

  localparam int NUM_COINS = 6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_EJECT  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [INV_W-1:0] TUBE_FULL = INV_W'(INV_INIT);
  localparam logic [INV_W-1:0] TUBE_ONE  = INV_W'(1);

  logic [1:0]       state;
  logic [15:0]      remain;
  logic [INV_W-1:0] tube_count [NUM_COINS];
  logic [2:0]       coin_code;
  logic [15:0]      short_amt;
  logic [7:0]       coins_out;

  logic             sel_found;
  logic [2:0]       sel_code;

  // Value in cents of each denomination code
  function automatic logic [15:0] coin_value(input logic [2:0] code);
    case (code)
      3'd0:    coin_value = 16'd1;
      3'd1:    coin_value = 16'd5;
      3'd2:    coin_value = 16'd10;
      3'd3:    coin_value = 16'd25;
      3'd4:    coin_value = 16'd100;
      3'd5:    coin_value = 16'd500;
      default: coin_value = 16'd0;
    endcase
  endfunction

  // Greedy pick: scanning upward, the last fitting stocked code is the largest
  always_comb begin
    sel_found = 1'b0;
    sel_code  = 3'd0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if ((coin_value(3'(i)) <= remain) && (tube_count[i] != '0)) begin
        sel_found = 1'b1;
        sel_code  = 3'(i);
      end
    end
  end

  assign bus.O_EJECT     = (state == ST_EJECT);
  assign bus.O_BUSY      = (state != ST_IDLE);
  assign bus.O_DONE      = (state == ST_DONE);
  assign bus.O_COIN      = coin_code;
  assign bus.O_SHORT     = short_amt;
  assign bus.O_COINS_OUT = coins_out;

  // Transaction sequencing, inventory bookkeeping and result registers
  always_ff @(posedge CLK) begin
    if (!I_RESET_N) begin
      state     <= ST_IDLE;
      remain    <= 16'd0;
      coin_code <= 3'd0;
      short_amt <= 16'd0;
      coins_out <= 8'd0;
      for (int i = 0; i < NUM_COINS; i++) begin
        tube_count[i] <= TUBE_FULL;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.I_REFILL) begin
            for (int i = 0; i < NUM_COINS; i++) begin
              tube_count[i] <= TUBE_FULL;
            end
          end
          if (bus.I_START) begin
            remain    <= bus.I_AMOUNT;
            short_amt <= 16'd0;
            coins_out <= 8'd0;
            state     <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (sel_found) begin
            coin_code <= sel_code;
            state     <= ST_EJECT;
          end else begin
            short_amt <= remain;
            state     <= ST_DONE;
          end
        end
        ST_EJECT: begin
          if (bus.I_EJECT_ACK) begin
            remain <= remain - coin_value(coin_code);
            for (int i = 0; i < NUM_COINS; i++) begin
              if (coin_code == 3'(i)) begin
                tube_count[i] <= tube_count[i] - TUBE_ONE;
              end
            end
            if (coins_out != 8'hFF) begin
              coins_out <= coins_out + 8'd1;
            end
            state <= ST_SELECT;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
